param_fifo: RTL and testbench



---
 rtl/param_fifo.sv | 77 +++++++
 tb/tb_param_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with programmable thresholds, occupancy count,
// sticky overflow/underflow flags, synchronous flush and registered or first-word-fall-through output.
module param_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LVL     = 6,
    parameter int AE_LVL     = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wren,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    rden,
    input  logic                    flush,
    input  logic                    clr_err,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AE_LVL < 0) || (AE_LVL >= AF_LVL) || (AF_LVL > DEPTH)) begin : g_bad_params
        $error("param_fifo: illegal DEPTH/AE_LVL/AF_LVL combination");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  rd_ok, rd_acc, wr_acc, ov_set, un_set;

    // A read on a full FIFO frees a slot, letting a same-cycle write through
    assign rd_ok  = rden && !empty;
    assign rd_acc = rd_ok && !flush;
    assign wr_acc = wren && (!full || rd_ok) && !flush;
    assign ov_set = wren && full && !rd_ok && !flush;
    assign un_set = rden && empty && !flush;

    assign empty        = count == '0;
    assign full         = count == CW'(DEPTH);
    assign almost_full  = count >= CW'(AF_LVL);
    assign almost_empty = count <= CW'(AE_LVL);

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= flush ? '0 : wr_ptr + AW'(wr_acc);
            rd_ptr    <= flush ? '0 : rd_ptr + AW'(rd_acc);
            count     <= flush ? '0 : count + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= ov_set || (overflow && !clr_err);
            underflow <= un_set || (underflow && !clr_err);
        end
    end

    if (FWFT) begin : g_fwft
        assign o_data = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) o_data <= '0;
            else if (rd_acc) o_data <= mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: drives registered-read and FWFT instances with shared stimulus and checks
// them against a queue-based reference model.
module tb_param_fifo;
    logic       clk = 1'b0, rst = 1'b1, wren = 1'b0, rden = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [7:0] i_data = '0;
    logic [7:0] o0, o1;
    logic [3:0] cnt0, cnt1;
    logic       full0, empty0, af0, ae0, ov0, un0;
    logic       full1, empty1, af1, ae1, ov1, un1;
    int         tests = 0, fails = 0;
    logic [7:0] q[$];
    logic [7:0] m_o0 = '0;
    logic       m_ov = 1'b0, m_un = 1'b0;

    param_fifo #(.FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .wren(wren), .i_data(i_data), .rden(rden), .flush(flush),
        .clr_err(clr_err), .o_data(o0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0)
    );

    param_fifo #(.FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wren(wren), .i_data(i_data), .rden(rden), .flush(flush),
        .clr_err(clr_err), .o_data(o1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_o0 = '0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    // One clock: model updates on the rising edge, caller checks at the following falling edge
    task automatic cyc();
        logic rd_ok, wr_ok;
        @(posedge clk);
        if (rst) model_clear();
        else if (flush) begin
            q.delete();
            m_ov = m_ov && !clr_err;
            m_un = m_un && !clr_err;
        end else begin
            rd_ok = rden && q.size() > 0;
            wr_ok = wren && (q.size() < 8 || rd_ok);
            m_ov  = (wren && !wr_ok) || (m_ov && !clr_err);
            m_un  = (rden && q.size() == 0) || (m_un && !clr_err);
            if (rd_ok) m_o0 = q.pop_front();
            if (wr_ok) q.push_back(i_data);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        wren = w;
        i_data = d;
        rden = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        model_clear();
        repeat (2) cyc();
        tests++; if ({empty0, ae0, full0, af0} !== 4'b1100) begin fails++; $display("FAIL reset_flags0 got %b want 1100", {empty0, ae0, full0, af0}); end
        tests++; if ({empty1, ae1, full1, af1} !== 4'b1100) begin fails++; $display("FAIL reset_flags1 got %b want 1100", {empty1, ae1, full1, af1}); end
        tests++; if ({cnt0, cnt1} !== 8'h00) begin fails++; $display("FAIL reset_count got %h/%h want 0", cnt0, cnt1); end
        tests++; if ({o0, o1} !== 16'h0000) begin fails++; $display("FAIL reset_odata got %h/%h want 0", o0, o1); end
        tests++; if ({ov0, un0, ov1, un1} !== 4'b0000) begin fails++; $display("FAIL reset_err got %b want 0000", {ov0, un0, ov1, un1}); end
    endtask

    task automatic test_fill();
        logic [6:0] e;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            cyc();
            e = {i <= 2, i >= 6, i == 8, 4'(i)};
            tests++; if ({ae0, af0, full0, cnt0} !== e) begin fails++; $display("FAIL fill_%0d got %b want %b", i, {ae0, af0, full0, cnt0}, e); end
            tests++; if (o1 !== 8'h01) begin fails++; $display("FAIL fill_head_%0d got %h want 01", i, o1); end
        end
        drive(1'b1, 8'h09, 1'b1);
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        tests++; if (o0 !== 8'h01) begin fails++; $display("FAIL full_rw_data got %h want 01", o0); end
        tests++; if ({full0, cnt0, ov0} !== 6'b1_1000_0) begin fails++; $display("FAIL full_rw_state got %b want 110000", {full0, cnt0, ov0}); end
        tests++; if (o1 !== 8'h02) begin fails++; $display("FAIL full_rw_head got %h want 02", o1); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            cyc();
            tests++; if (o0 !== 8'(i + 2)) begin fails++; $display("FAIL drain_%0d got %h want %h", i, o0, 8'(i + 2)); end
            tests++; if (o1 !== (i < 7 ? 8'(i + 3) : 8'h00)) begin fails++; $display("FAIL drain_head_%0d got %h", i, o1); end
        end
        tests++; if ({empty0, empty1} !== 2'b11) begin fails++; $display("FAIL drain_empty got %b want 11", {empty0, empty1}); end
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        tests++; if (o0 !== 8'h09) begin fails++; $display("FAIL underflow_hold got %h want 09", o0); end
        tests++; if ({un0, un1} !== 2'b11) begin fails++; $display("FAIL underflow_set got %b want 11", {un0, un1}); end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        tests++; if ({un0, un1} !== 2'b00) begin fails++; $display("FAIL underflow_clr got %b want 00", {un0, un1}); end
    endtask

    task automatic test_overflow();
        logic [7:0] d[8];
        for (int i = 0; i < 8; i++) begin
            d[i] = 8'($urandom);
            drive(1'b1, d[i], 1'b0);
            cyc();
        end
        drive(1'b1, 8'hEE, 1'b0);
        cyc();
        tests++; if ({ov0, ov1, cnt0} !== 6'b11_1000) begin fails++; $display("FAIL overflow_set got %b want 111000", {ov0, ov1, cnt0}); end
        clr_err = 1'b1;
        cyc();
        tests++; if ({ov0, ov1} !== 2'b11) begin fails++; $display("FAIL overflow_set_wins got %b want 11", {ov0, ov1}); end
        drive(1'b0, 8'h00, 1'b0);
        cyc();
        clr_err = 1'b0;
        tests++; if ({ov0, ov1} !== 2'b00) begin fails++; $display("FAIL overflow_clr got %b want 00", {ov0, ov1}); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (o1 !== d[i]) begin fails++; $display("FAIL ovf_head_%0d got %h want %h", i, o1, d[i]); end
            drive(1'b0, 8'h00, 1'b1);
            cyc();
            tests++; if (o0 !== d[i]) begin fails++; $display("FAIL ovf_read_%0d got %h want %h", i, o0, d[i]); end
        end
        drive(1'b0, 8'h00, 1'b0);
        tests++; if ({empty0, empty1} !== 2'b11) begin fails++; $display("FAIL ovf_empty got %b want 11", {empty0, empty1}); end
    endtask

    task automatic test_fwft();
        logic [7:0] last;
        last = o0;
        drive(1'b1, 8'hA5, 1'b0);
        cyc();
        tests++; if ({o1, empty1} !== {8'hA5, 1'b0}) begin fails++; $display("FAIL fwft_first got %h/%b want a5/0", o1, empty1); end
        tests++; if (o0 !== last) begin fails++; $display("FAIL reg_hold got %h want %h", o0, last); end
        drive(1'b1, 8'h3C, 1'b0);
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        tests++; if ({o1, o0} !== 16'h3CA5) begin fails++; $display("FAIL fwft_next got %h/%h want 3c/a5", o1, o0); end
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        tests++; if ({empty1, o1} !== {1'b1, 8'h00}) begin fails++; $display("FAIL fwft_empty got %b/%h want 1/00", empty1, o1); end
        tests++; if (o0 !== 8'h3C) begin fails++; $display("FAIL reg_last got %h want 3c", o0); end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            cyc();
        end
        tests++; if ({cnt0, cnt1} !== 8'h55) begin fails++; $display("FAIL flush_load got %h/%h want 5", cnt0, cnt1); end
        flush = 1'b1;
        drive(1'b1, 8'h77, 1'b0);
        cyc();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        tests++; if ({cnt0, empty0, ae0, cnt1, empty1, o1} !== {4'd0, 2'b11, 4'd0, 1'b1, 8'h00}) begin fails++; $display("FAIL flush_state got %h %b%b %h %b %h", cnt0, empty0, ae0, cnt1, empty1, o1); end
        tests++; if ({o0, ov0, un0} !== {8'h3C, 2'b00}) begin fails++; $display("FAIL flush_hold got %h %b%b want 3c 00", o0, ov0, un0); end
        cyc();
        tests++; if ({cnt0, cnt1} !== 8'h00) begin fails++; $display("FAIL flush_no_write got %h/%h want 0", cnt0, cnt1); end
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0);
            cyc();
        end
        tests++; if ({un0, cnt0, o1} !== {1'b1, 4'd3, 8'h40}) begin fails++; $display("FAIL pre_reset got %b %h %h", un0, cnt0, o1); end
        #2 rst = 1'b1;
        #1;
        tests++; if ({cnt0, empty0, ae0, full0, af0, o0, ov0, un0} !== {4'd0, 4'b1100, 8'h00, 2'b00}) begin fails++; $display("FAIL async_reset0 got %h %b%b%b%b %h %b%b", cnt0, empty0, ae0, full0, af0, o0, ov0, un0); end
        tests++; if ({cnt1, empty1, o1, un1} !== {4'd0, 1'b1, 8'h00, 1'b0}) begin fails++; $display("FAIL async_reset1 got %h %b %h %b", cnt1, empty1, o1, un1); end
        model_clear();
        cyc();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        cyc();
        tests++; if ({empty0, empty1, cnt0} !== 6'b11_0000) begin fails++; $display("FAIL post_reset got %b%b %h", empty0, empty1, cnt0); end
    endtask

    task automatic test_random();
        logic [15:0] g0, e0, g1, e1;
        int          n;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 99) < (c < 300 ? 70 : 35), 8'($urandom), $urandom_range(0, 99) < (c < 300 ? 35 : 70));
            flush = $urandom_range(0, 31) == 0;
            clr_err = $urandom_range(0, 15) == 0;
            cyc();
            n  = q.size();
            g0 = {o0, cnt0, full0, empty0, af0, ae0};
            e0 = {m_o0, 4'(n), n == 8, n == 0, n >= 6, n <= 2};
            g1 = {o1, cnt1, full1, empty1, af1, ae1};
            e1 = {n > 0 ? q[0] : 8'h00, 4'(n), n == 8, n == 0, n >= 6, n <= 2};
            tests++; if ({g0, ov0, un0} !== {e0, m_ov, m_un}) begin fails++; $display("FAIL rand_reg_%0d got %h %b%b want %h %b%b", c, g0, ov0, un0, e0, m_ov, m_un); end
            tests++; if ({g1, ov1, un1} !== {e1, m_ov, m_un}) begin fails++; $display("FAIL rand_fwft_%0d got %h %b%b want %h %b%b", c, g1, ov1, un1, e1, m_ov, m_un); end
        end
        drive(1'b0, 8'h00, 1'b0);
        flush = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_fwft();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
